// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-index counter: clear has priority, wraps to 0 after WIDTH-1.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_en,
    output logic [cnt_width(WIDTH)-1:0] o_cnt,
    output logic                        o_tc
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc  = (r_cnt == LAST);
    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer with valid/ready load, stall and
// frame-done pulse; back-to-back frames run without an idle gap.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    piso_state_t      r_state;
    piso_state_t      w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;
    logic             w_next_bit;
    logic             w_first_bit;
    logic             r_sout;
    logic             r_done;
    logic [CW-1:0]    w_idx;
    logic             w_tc;
    logic             w_xfer;
    logic             w_consume;
    logic             w_last_consume;

    assign w_xfer         = load_valid && load_ready;
    assign w_consume      = (r_state == SHIFT) && shift_en;
    assign w_last_consume = w_consume && w_tc;

    assign w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};
    assign w_next_bit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];
    assign w_first_bit = MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_xfer),
        .i_en  (w_consume),
        .o_cnt (w_idx),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_last_consume && !w_xfer) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        last_bit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                load_ready = !rst;
            end
            SHIFT: begin
                serial_valid = 1'b1;
                busy         = 1'b1;
                last_bit     = w_tc;
                load_ready   = !rst && w_tc && shift_en;
            end
            default: ;
        endcase
    end

    // A reload on the last consume takes priority over the idle drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_sout  <= IDLE_LEVEL;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last_consume;
            if (w_xfer) begin
                r_shreg <= parallel_in;
                r_sout  <= w_first_bit;
            end else if (w_consume) begin
                r_shreg <= w_shifted;
                r_sout  <= w_tc ? IDLE_LEVEL : w_next_bit;
            end
        end
    end

    assign serial_out = r_sout;
    assign done       = r_done;

    logic w_unused;
    assign w_unused = ^w_idx;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed table-driven bench: WIDTH=4, MSB-first and LSB-first
// instances share stimulus and are checked cycle by cycle.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] parallel_in;
    logic       shift_en;

    logic m_rdy, m_sout, m_sval, m_last, m_busy, m_done;
    logic l_rdy, l_sout, l_sval, l_last, l_busy, l_done;

    int n_checks = 0;
    int n_errors = 0;
    int row      = 0;

    always #5 clk = ~clk;

    piso_serializer #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) u_msb (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (m_rdy),
        .parallel_in  (parallel_in),
        .shift_en     (shift_en),
        .serial_out   (m_sout),
        .serial_valid (m_sval),
        .last_bit     (m_last),
        .busy         (m_busy),
        .done         (m_done)
    );

    piso_serializer #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (l_rdy),
        .parallel_in  (parallel_in),
        .shift_en     (shift_en),
        .serial_out   (l_sout),
        .serial_valid (l_sval),
        .last_bit     (l_last),
        .busy         (l_busy),
        .done         (l_done)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] pin;
        logic       se;
        logic       msb;
        logic       lsb;
        logic       sval;
        logic       last;
        logic       busy;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] B = 4'b1011;
    localparam logic [3:0] C = 4'b0110;
    localparam logic [3:0] Z = 4'b0000;

    task automatic add(input logic r, input logic lv, input logic [3:0] p,
                       input logic se, input logic ms, input logic ls,
                       input logic sv, input logic la, input logic bu,
                       input logic dn, input logic rd);
        vec_t v;
        v.rst = r;  v.lv = lv; v.pin = p;   v.se = se;
        v.msb = ms; v.lsb = ls; v.sval = sv; v.last = la;
        v.busy = bu; v.done = dn; v.rdy = rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic lv, input logic [3:0] p,
                         input logic se);
        rst = r; load_valid = lv; parallel_in = p; shift_en = se;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // rst lv pin se | msb lsb sval last busy done rdy
        add(1, 0, Z, 1,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, B, 1,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, Z, 1,  1, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  0, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  1, 0, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  1, 1, 1, 1, 1, 0, 1);
        add(0, 0, Z, 0,  0, 0, 0, 0, 0, 1, 1);
        add(0, 0, Z, 0,  0, 0, 0, 0, 0, 0, 1);
        // back-to-back frames 1011 then 0110
        add(0, 1, B, 1,  0, 0, 0, 0, 0, 0, 1);
        add(0, 1, C, 1,  1, 1, 1, 0, 1, 0, 0);
        add(0, 1, C, 1,  0, 1, 1, 0, 1, 0, 0);
        add(0, 1, C, 1,  1, 0, 1, 0, 1, 0, 0);
        add(0, 1, C, 1,  1, 1, 1, 1, 1, 0, 1);
        add(0, 0, Z, 1,  0, 0, 1, 0, 1, 1, 0);
        add(0, 0, Z, 1,  1, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  1, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  0, 0, 1, 1, 1, 0, 1);
        add(0, 0, Z, 1,  0, 0, 0, 0, 0, 1, 1);
        // stall three cycles on bit 1
        add(0, 1, B, 1,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, Z, 1,  1, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 0,  0, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 0,  0, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 0,  0, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  0, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  1, 0, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  1, 1, 1, 1, 1, 0, 1);
        add(0, 0, Z, 1,  0, 0, 0, 0, 0, 1, 1);
        // load offered mid-frame, then stall on the last bit
        add(0, 1, B, 1,  0, 0, 0, 0, 0, 0, 1);
        add(0, 0, Z, 1,  1, 1, 1, 0, 1, 0, 0);
        add(0, 0, Z, 1,  0, 1, 1, 0, 1, 0, 0);
        add(0, 1, Z, 1,  1, 0, 1, 0, 1, 0, 0);
        add(0, 0, Z, 0,  1, 1, 1, 1, 1, 0, 0);
        add(0, 0, Z, 1,  1, 1, 1, 1, 1, 0, 1);
        add(0, 0, Z, 1,  0, 0, 0, 0, 0, 1, 1);

        drive(1, 0, Z, 1);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            drive(vecs[i].rst, vecs[i].lv, vecs[i].pin, vecs[i].se);
            chk("msb_sout", m_sout, vecs[i].msb);
            chk("lsb_sout", l_sout, vecs[i].lsb);
            chk("msb_sval", m_sval, vecs[i].sval);
            chk("lsb_sval", l_sval, vecs[i].sval);
            chk("msb_last", m_last, vecs[i].last);
            chk("lsb_last", l_last, vecs[i].last);
            chk("msb_busy", m_busy, vecs[i].busy);
            chk("lsb_busy", l_busy, vecs[i].busy);
            chk("msb_done", m_done, vecs[i].done);
            chk("lsb_done", l_done, vecs[i].done);
            chk("msb_rdy", m_rdy, vecs[i].rdy);
            chk("lsb_rdy", l_rdy, vecs[i].rdy);
            tick();
        end

        // reset during bit 2 aborts the frame with no done pulse
        row = 100;
        drive(0, 1, B, 1);
        tick();
        drive(0, 0, Z, 1);
        tick();
        tick();
        row = 101;
        drive(1, 1, C, 1);
        chk("rst_sout_before", m_sout, 1'b1);
        chk("rst_rdy_in_rst", m_rdy, 1'b0);
        chk("rst_rdy_in_rst_l", l_rdy, 1'b0);
        tick();
        row = 102;
        drive(0, 0, Z, 1);
        chk("rst_sout", m_sout, 1'b0);
        chk("rst_sout_l", l_sout, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_sval", m_sval, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_rdy", m_rdy, 1'b1);
        tick();
        row = 103;
        drive(0, 1, C, 1);
        chk("rst_done_after", m_done, 1'b0);
        chk("rst_done_after_l", l_done, 1'b0);
        chk("rst_idle_rdy", m_rdy, 1'b1);
        tick();
        row = 104;
        drive(0, 0, Z, 1);
        chk("reload_sval", m_sval, 1'b1);
        chk("reload_msb", m_sout, 1'b0);
        tick();
        row = 105;
        chk("reload_msb_b1", m_sout, 1'b1);
        chk("reload_lsb_b1", l_sout, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, shift-enable stall and frame-done signalling. It supersedes the fixed 4-bit PISO and sits between a word-oriented producer and a bit-serial link. It supports gapless back-to-back frames.

## Interface
- `WIDTH`, 8: bits per frame; must be at least 2.
- `MSB_FIRST`, 1: 1 sends `parallel_in[WIDTH-1]` first; 0 sends bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `serial_out` when no frame is active.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  producer offers `parallel_in`.
- `load_ready`  out  1  block accepts the word; transfer occurs when `load_valid && load_ready` at a rising edge.
- `parallel_in`  in  WIDTH  frame word; sampled only on transfer.
- `shift_en`  in  1  downstream consumes the current bit this cycle; 0 stalls.
- `serial_out`  out  1  current serial bit (registered).
- `serial_valid`  out  1  `serial_out` carries a frame bit.
- `last_bit`  out  1  `serial_valid && (bit index == WIDTH-1)`.
- `busy`  out  1  a frame is in progress (state SHIFT).
- `done`  out  1  one-cycle pulse, registered, after the last bit is consumed.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE:
  - `load_ready=1`, `serial_valid=0`, `serial_out=IDLE_LEVEL`.
  - On transfer: load the shift register, clear the bit index to 0, go to SHIFT.
- SHIFT:
  - `serial_out` shows the bit at the current index in the selected order.
  - When `shift_en=1`: advance the register by one bit and increment the index.
  - When `shift_en=0`: hold all state, including `serial_out`.
- Last bit consumed (index WIDTH-1 and `shift_en=1`):
  - With a simultaneous transfer: reload, index goes to 0, stay in SHIFT. There is no idle cycle between frames.
  - Without a transfer: go to IDLE and drive `serial_out` to `IDLE_LEVEL`.
  - In both cases `done` pulses in the next cycle.
- `load_ready` = `!rst && (IDLE || (SHIFT && index==WIDTH-1 && shift_en))`. It is combinational and never asserted mid-frame otherwise.
- `load_valid` while not ready is ignored. `parallel_in` is not sampled and there is no queueing.
- Bit index counter width is `$clog2(WIDTH)`. It counts 0..WIDTH-1 and never wraps inside a frame.
- Register shift direction:
  - MSB_FIRST=1: left shift, output from the MSB.
  - MSB_FIRST=0: right shift, output from the LSB.
  - Vacated bits fill with 0.

## Timing
- Reset values, held while `rst=1`: state IDLE, `serial_out=IDLE_LEVEL`, `serial_valid=0`, `busy=0`, `done=0`, `last_bit=0`, `load_ready=0`, shift register and index 0.
- `rst` overrides every other input in the same cycle.
- Reset mid-frame aborts the frame immediately. No `done` pulse follows.
- Latency: transfer at edge N puts the first bit on `serial_out` with `serial_valid=1` from edge N to N+1.
- With no stalls, a frame occupies exactly WIDTH cycles.
- Stalls: each `shift_en=0` cycle in SHIFT extends the frame by one cycle.
- `shift_en` in IDLE has no effect.
- `done` is high for exactly one cycle, starting at the edge after the last-bit consume. In back-to-back operation it coincides with bit 0 of the next frame.
- Throughput: one bit per `shift_en` cycle. The line is saturated with `load_valid` and `shift_en` held high.

## Structure
- Shared package `piso_pkg`:
  - state enum `piso_state_t` (IDLE, SHIFT).
  - function computing the counter width from WIDTH.
- Sub-module `piso_bit_cnt`:
  - parametrised index counter with clear, enable and a terminal-count flag.
- Top level holds the FSM, shift register, output registers and handshake logic.

## Test plan
- WIDTH=4, MSB_FIRST=1:
  - Stimulus: load 4'b1011, `shift_en=1`.
  - Required: `serial_out` 1,0,1,1 on the 4 cycles after the transfer; `last_bit` on the 4th; `done` on the 5th; then `IDLE_LEVEL`.
- WIDTH=4, MSB_FIRST=0:
  - Stimulus: load 4'b1011.
  - Required: `serial_out` 1,1,0,1.
- Back-to-back frames:
  - Stimulus: hold `load_valid`, present 4'b1011 then 4'b0110.
  - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0; `serial_valid` never drops; `done` pulses once coincident with bit 0 of frame 2, and once after bit 7.
- Stall:
  - Stimulus: load 4'b1011; drop `shift_en` for 3 cycles after bit 1.
  - Required: `serial_out` holds 0 for 4 cycles; frame length 7 cycles; bit sequence unchanged.
- Load while busy:
  - Stimulus: assert `load_valid` with 4'b0000 during bit 2 of frame 4'b1011.
  - Required: `load_ready=0`; output sequence unaffected.
- Reset mid-frame:
  - Stimulus: assert `rst` during bit 2, one cycle.
  - Required: next cycle `serial_out=IDLE_LEVEL`, `busy=0`, no `done`; `load_ready=1` once `rst` is low.
